// File: rtl/rgmii_rx_frame.sv
// RGMII receive framer: rebuilds GMII bytes, strips preamble/SFD, delimits frames, decodes in-band status.
// Latency: payload byte registered 1 cycle after its DDR sample; no backpressure, the line rate is imposed by the PHY.
module rgmii_rx_frame #(
    parameter int MIN_PREAMBLE = 1,
    parameter int MAX_LEN      = 1522
) (
    input  logic        rgmii_rxclk,
    input  logic        rst,
    input  logic [3:0]  rxd_rise,
    input  logic [3:0]  rxd_fall,
    input  logic        rxctl_rise,
    input  logic        rxctl_fall,
    output logic [7:0]  gmii_rxd,
    output logic        gmii_rxdv,
    output logic        gmii_rxer,
    output logic        frame_start,
    output logic        frame_end,
    output logic [15:0] frame_len,
    output logic        frame_err,
    output logic        sfd_err,
    output logic        link_up,
    output logic [1:0]  link_speed,
    output logic        link_duplex
);

    typedef enum logic [1:0] {S_IDLE, S_PRE, S_DATA, S_DROP} state_t;

    state_t      state_q, state_d;
    logic [3:0]  pre_cnt_q, pre_cnt_d;
    logic [15:0] len_q, len_d;
    logic        err_q, err_d;
    logic [7:0]  rxd_q, rxd_d;
    logic        rxdv_q, rxdv_d;
    logic        rxer_q, rxer_d;
    logic        fs_q, fs_d;
    logic        fe_q, fe_d;
    logic [15:0] flen_q, flen_d;
    logic        ferr_q, ferr_d;
    logic        sfd_q, sfd_d;
    logic        up_q, up_d;
    logic [1:0]  spd_q, spd_d;
    logic        dup_q, dup_d;

    logic [7:0]  byte_in;
    logic        dv;
    logic        er;
    logic [15:0] len_inc;
    logic [3:0]  pre_inc;

    assign byte_in = {rxd_fall, rxd_rise};
    assign dv      = rxctl_rise;
    assign er      = rxctl_rise ^ rxctl_fall;
    assign len_inc = (len_q == 16'hFFFF) ? len_q : len_q + 16'd1;
    assign pre_inc = (pre_cnt_q == 4'hF) ? pre_cnt_q : pre_cnt_q + 4'd1;

    always_comb begin
        state_d   = state_q;
        pre_cnt_d = pre_cnt_q;
        len_d     = len_q;
        err_d     = err_q;
        rxd_d     = 8'h00;
        rxdv_d    = 1'b0;
        rxer_d    = 1'b0;
        fs_d      = 1'b0;
        fe_d      = 1'b0;
        flen_d    = flen_q;
        ferr_d    = ferr_q;
        sfd_d     = 1'b0;
        up_d      = up_q;
        spd_d     = spd_q;
        dup_d     = dup_q;

        case (state_q)
            S_IDLE: begin
                if (!dv) begin
                    // Carrier-extend / false-carrier gaps carry no valid status.
                    if (!er) begin
                        up_d  = rxd_rise[0];
                        spd_d = rxd_rise[2:1];
                        dup_d = rxd_rise[3];
                    end
                end else if (!er && byte_in == 8'h55) begin
                    state_d   = S_PRE;
                    pre_cnt_d = 4'd1;
                end else if (!er && byte_in == 8'hD5 && MIN_PREAMBLE == 0) begin
                    state_d = S_DATA;
                    len_d   = 16'd0;
                    err_d   = 1'b0;
                end else begin
                    state_d = S_DROP;
                    sfd_d   = 1'b1;
                end
            end
            S_PRE: begin
                if (!dv) begin
                    state_d = S_IDLE;
                    sfd_d   = 1'b1;
                end else if (er) begin
                    state_d = S_DROP;
                    sfd_d   = 1'b1;
                end else if (byte_in == 8'h55) begin
                    pre_cnt_d = pre_inc;
                end else if (byte_in == 8'hD5 && 32'(pre_cnt_q) >= MIN_PREAMBLE) begin
                    state_d = S_DATA;
                    len_d   = 16'd0;
                    err_d   = 1'b0;
                end else begin
                    state_d = S_DROP;
                    sfd_d   = 1'b1;
                end
            end
            S_DATA: begin
                if (dv) begin
                    rxd_d  = byte_in;
                    rxdv_d = 1'b1;
                    rxer_d = er;
                    fs_d   = (len_q == 16'd0);
                    len_d  = len_inc;
                    if (er || 32'(len_inc) > MAX_LEN) begin
                        err_d = 1'b1;
                    end
                end else begin
                    state_d = S_IDLE;
                    fe_d    = 1'b1;
                    flen_d  = len_q;
                    ferr_d  = err_q;
                end
            end
            S_DROP: begin
                if (!dv) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge rgmii_rxclk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            pre_cnt_q <= 4'd0;
            len_q     <= 16'd0;
            err_q     <= 1'b0;
            rxd_q     <= 8'h00;
            rxdv_q    <= 1'b0;
            rxer_q    <= 1'b0;
            fs_q      <= 1'b0;
            fe_q      <= 1'b0;
            flen_q    <= 16'd0;
            ferr_q    <= 1'b0;
            sfd_q     <= 1'b0;
            up_q      <= 1'b0;
            spd_q     <= 2'b00;
            dup_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            pre_cnt_q <= pre_cnt_d;
            len_q     <= len_d;
            err_q     <= err_d;
            rxd_q     <= rxd_d;
            rxdv_q    <= rxdv_d;
            rxer_q    <= rxer_d;
            fs_q      <= fs_d;
            fe_q      <= fe_d;
            flen_q    <= flen_d;
            ferr_q    <= ferr_d;
            sfd_q     <= sfd_d;
            up_q      <= up_d;
            spd_q     <= spd_d;
            dup_q     <= dup_d;
        end
    end

    assign gmii_rxd    = rxd_q;
    assign gmii_rxdv   = rxdv_q;
    assign gmii_rxer   = rxer_q;
    assign frame_start = fs_q;
    assign frame_end   = fe_q;
    assign frame_len   = flen_q;
    assign frame_err   = ferr_q;
    assign sfd_err     = sfd_q;
    assign link_up     = up_q;
    assign link_speed  = spd_q;
    assign link_duplex = dup_q;

endmodule

// File: tb/tb_rgmii_rx_frame.sv
// Directed bench for rgmii_rx_frame: vector table for single-cycle behaviour, hand sequences for whole frames.
module tb_rgmii_rx_frame;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  rxd_rise = 4'h0;
    logic [3:0]  rxd_fall = 4'h0;
    logic        rxctl_rise = 1'b0;
    logic        rxctl_fall = 1'b0;

    logic [7:0]  a_rxd, b_rxd;
    logic        a_rxdv, b_rxdv, a_rxer, b_rxer, a_fs, b_fs, a_fe, b_fe;
    logic [15:0] a_len, b_len;
    logic        a_ferr, b_ferr, a_sfd, b_sfd, a_up, b_up, a_dup, b_dup;
    logic [1:0]  a_spd, b_spd;

    always #5 clk = ~clk;

    rgmii_rx_frame #(.MIN_PREAMBLE(1), .MAX_LEN(1522)) dut (
        .rgmii_rxclk(clk), .rst(rst), .rxd_rise(rxd_rise), .rxd_fall(rxd_fall),
        .rxctl_rise(rxctl_rise), .rxctl_fall(rxctl_fall),
        .gmii_rxd(a_rxd), .gmii_rxdv(a_rxdv), .gmii_rxer(a_rxer),
        .frame_start(a_fs), .frame_end(a_fe), .frame_len(a_len), .frame_err(a_ferr),
        .sfd_err(a_sfd), .link_up(a_up), .link_speed(a_spd), .link_duplex(a_dup)
    );

    // Small-MAX_LEN instance sharing the same input stream, for oversize checks.
    rgmii_rx_frame #(.MIN_PREAMBLE(1), .MAX_LEN(16)) dut_s (
        .rgmii_rxclk(clk), .rst(rst), .rxd_rise(rxd_rise), .rxd_fall(rxd_fall),
        .rxctl_rise(rxctl_rise), .rxctl_fall(rxctl_fall),
        .gmii_rxd(b_rxd), .gmii_rxdv(b_rxdv), .gmii_rxer(b_rxer),
        .frame_start(b_fs), .frame_end(b_fe), .frame_len(b_len), .frame_err(b_ferr),
        .sfd_err(b_sfd), .link_up(b_up), .link_speed(b_spd), .link_duplex(b_dup)
    );

    typedef struct packed {
        logic [7:0]  rxd;
        logic        dv;
        logic        er;
        logic        fs;
        logic        fe;
        logic [15:0] len;
        logic        ferr;
        logic        sfd;
        logic        up;
        logic [1:0]  spd;
        logic        dup;
    } out_t;

    typedef struct packed {
        logic       rst;
        logic       dv;
        logic       er;
        logic [7:0] b;
        out_t       exp;
    } vec_t;

    vec_t vecs[$];
    int   chk_cnt = 0;
    int   pass_cnt = 0;

    function automatic out_t cur(input bit s);
        out_t o;
        if (s) o = '{b_rxd, b_rxdv, b_rxer, b_fs, b_fe, b_len, b_ferr, b_sfd, b_up, b_spd, b_dup};
        else   o = '{a_rxd, a_rxdv, a_rxer, a_fs, a_fe, a_len, a_ferr, a_sfd, a_up, a_spd, a_dup};
        return o;
    endfunction

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
        chk_cnt++;
        if (got === want) pass_cnt++;
        else $display("FAIL %s: got %h, want %h", name, got, want);
    endtask

    task automatic add(input logic r, input logic dv, input logic er, input logic [7:0] b,
                       input logic [7:0] rxd, input logic odv, input logic oer, input logic fs,
                       input logic fe, input logic [15:0] len, input logic ferr, input logic sfd,
                       input logic up, input logic [1:0] spd, input logic dup);
        vec_t v;
        v.rst = r; v.dv = dv; v.er = er; v.b = b;
        v.exp = '{rxd, odv, oer, fs, fe, len, ferr, sfd, up, spd, dup};
        vecs.push_back(v);
    endtask

    // Drive one DDR sample at the falling edge; outputs are read 1 ns after the next rising edge.
    task automatic send(input logic r, input logic [7:0] b, input logic dv, input logic er);
        @(negedge clk);
        rst        = r;
        rxd_rise   = b[3:0];
        rxd_fall   = b[7:4];
        rxctl_rise = dv;
        rxctl_fall = dv ^ er;
        @(posedge clk);
        #1;
    endtask

    task automatic run_frame(input int n, input int er_idx, input bit s, input logic ferr);
        out_t o;
        for (int k = 0; k < 8; k++) begin
            send(1'b0, (k == 7) ? 8'hD5 : 8'h55, 1'b1, 1'b0);
            o = cur(s);
            chk("preamble_quiet", {o.dv, o.fs, o.fe, o.sfd}, 4'b0000);
        end
        for (int i = 0; i < n; i++) begin
            send(1'b0, 8'(i), 1'b1, i == er_idx);
            o = cur(s);
            chk("payload", {o.rxd, o.dv, o.er, o.fs, o.fe},
                {8'(i), 1'b1, 1'(i == er_idx), 1'(i == 0), 1'b0});
        end
        send(1'b0, 8'h0D, 1'b0, 1'b0);
        o = cur(s);
        chk("frame_end", {o.dv, o.fe, o.len, o.ferr}, {1'b0, 1'b1, 16'(n), ferr});
        send(1'b0, 8'h0D, 1'b0, 1'b0);
        o = cur(s);
        chk("end_pulse_hold", {o.fe, o.len, o.ferr}, {1'b0, 16'(n), ferr});
    endtask

    initial begin
        out_t o;
        //   rst dv er byte   rxd  dv er fs fe len ferr sfd up spd dup
        add(1, 0, 0, 8'h00, 8'h00, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0);
        add(0, 0, 0, 8'h0D, 8'h00, 0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 1);
        add(0, 0, 1, 8'h00, 8'h00, 0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 1);
        add(0, 1, 0, 8'h55, 8'h00, 0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 1);
        add(0, 1, 0, 8'h55, 8'h00, 0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 1);
        add(0, 1, 0, 8'hD5, 8'h00, 0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 1);
        add(0, 1, 0, 8'hAB, 8'hAB, 1, 0, 1, 0, 0, 0, 0, 1, 2'b10, 1);
        add(0, 1, 1, 8'h3C, 8'h3C, 1, 1, 0, 0, 0, 0, 0, 1, 2'b10, 1);
        add(0, 0, 0, 8'h0D, 8'h00, 0, 0, 0, 1, 2, 1, 0, 1, 2'b10, 1);
        add(0, 0, 0, 8'h00, 8'h00, 0, 0, 0, 0, 2, 1, 0, 0, 2'b00, 0);
        add(0, 1, 0, 8'h55, 8'h00, 0, 0, 0, 0, 2, 1, 0, 0, 2'b00, 0);
        add(0, 1, 0, 8'hD4, 8'h00, 0, 0, 0, 0, 2, 1, 1, 0, 2'b00, 0);
        add(0, 1, 0, 8'h12, 8'h00, 0, 0, 0, 0, 2, 1, 0, 0, 2'b00, 0);
        add(0, 0, 0, 8'h0B, 8'h00, 0, 0, 0, 0, 2, 1, 0, 0, 2'b00, 0);
        add(0, 0, 0, 8'h0B, 8'h00, 0, 0, 0, 0, 2, 1, 0, 1, 2'b01, 1);
        add(0, 1, 0, 8'h42, 8'h00, 0, 0, 0, 0, 2, 1, 1, 1, 2'b01, 1);
        add(0, 0, 0, 8'h0B, 8'h00, 0, 0, 0, 0, 2, 1, 0, 1, 2'b01, 1);
        add(0, 1, 0, 8'hD5, 8'h00, 0, 0, 0, 0, 2, 1, 1, 1, 2'b01, 1);
        add(0, 0, 0, 8'h0B, 8'h00, 0, 0, 0, 0, 2, 1, 0, 1, 2'b01, 1);
        add(0, 0, 0, 8'h0B, 8'h00, 0, 0, 0, 0, 2, 1, 0, 1, 2'b01, 1);
        add(0, 1, 0, 8'h55, 8'h00, 0, 0, 0, 0, 2, 1, 0, 1, 2'b01, 1);
        add(0, 0, 0, 8'h0B, 8'h00, 0, 0, 0, 0, 2, 1, 1, 1, 2'b01, 1);
        add(0, 0, 0, 8'h00, 8'h00, 0, 0, 0, 0, 2, 1, 0, 0, 2'b00, 0);
        add(0, 0, 0, 8'h0D, 8'h00, 0, 0, 0, 0, 2, 1, 0, 1, 2'b10, 1);
        add(0, 1, 0, 8'h55, 8'h00, 0, 0, 0, 0, 2, 1, 0, 1, 2'b10, 1);
        add(0, 1, 1, 8'h55, 8'h00, 0, 0, 0, 0, 2, 1, 1, 1, 2'b10, 1);
        add(0, 0, 0, 8'h0D, 8'h00, 0, 0, 0, 0, 2, 1, 0, 1, 2'b10, 1);

        send(1'b1, 8'h00, 1'b0, 1'b0);
        for (int i = 0; i < vecs.size(); i++) begin
            send(vecs[i].rst, vecs[i].b, vecs[i].dv, vecs[i].er);
            chk($sformatf("vec%0d", i), cur(0), vecs[i].exp);
        end

        run_frame(64, -1, 1'b0, 1'b0);   // nominal
        run_frame(20, 4, 1'b1, 1'b1);    // rx error + oversize on MAX_LEN=16
        run_frame(16, -1, 1'b1, 1'b0);   // exactly MAX_LEN
        run_frame(17, -1, 1'b1, 1'b1);   // one over MAX_LEN

        // Back-to-back 1-byte frames with a single dv=0 gap.
        send(1'b0, 8'h55, 1'b1, 1'b0);
        send(1'b0, 8'hD5, 1'b1, 1'b0);
        send(1'b0, 8'hAA, 1'b1, 1'b0);
        o = cur(0);
        chk("b2b_first_byte", {o.rxd, o.dv, o.fs, o.fe}, {8'hAA, 1'b1, 1'b1, 1'b0});
        send(1'b0, 8'h0D, 1'b0, 1'b0);
        o = cur(0);
        chk("b2b_first_end", {o.dv, o.fe, o.len, o.ferr}, {1'b0, 1'b1, 16'd1, 1'b0});
        send(1'b0, 8'h55, 1'b1, 1'b0);
        o = cur(0);
        chk("b2b_gap", {o.dv, o.fe, o.sfd}, 3'b000);
        send(1'b0, 8'hD5, 1'b1, 1'b0);
        send(1'b0, 8'hBB, 1'b1, 1'b0);
        o = cur(0);
        chk("b2b_second_byte", {o.rxd, o.dv, o.fs, o.fe}, {8'hBB, 1'b1, 1'b1, 1'b0});
        send(1'b0, 8'h0D, 1'b0, 1'b0);
        o = cur(0);
        chk("b2b_second_end", {o.fe, o.len, o.ferr}, {1'b1, 16'd1, 1'b0});
        send(1'b0, 8'h0D, 1'b0, 1'b0);

        // Reset in the middle of a 64-byte frame.
        for (int k = 0; k < 8; k++) send(1'b0, (k == 7) ? 8'hD5 : 8'h55, 1'b1, 1'b0);
        for (int i = 0; i < 10; i++) send(1'b0, 8'(i), 1'b1, 1'b0);
        send(1'b1, 8'd10, 1'b1, 1'b0);
        chk("mid_reset_values", cur(0), 34'd0);
        for (int i = 11; i < 64; i++) begin
            send(1'b0, 8'(i), 1'b1, 1'b0);
            o = cur(0);
            chk("post_reset_drop", {o.dv, o.fs, o.fe}, 3'b000);
        end
        send(1'b0, 8'h0D, 1'b0, 1'b0);
        o = cur(0);
        chk("post_reset_no_end", {o.fe, o.len}, {1'b0, 16'd0});
        send(1'b0, 8'h0D, 1'b0, 1'b0);
        run_frame(64, -1, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
